// File: rtl/mem_pkg.sv
// Shared state encoding and constants for the two-port memory arbiter.
package mem_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam int DEF_TIMEOUT = 255;
    localparam int CNT_W       = 8;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to the side not granted last.
// Purely combinational; grant is meaningless when req is zero.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       grant
);

    always_comb begin
        case (req)
            2'b10:   grant = 1'b1;
            2'b11:   grant = ~last_grant;
            default: grant = 1'b0;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between an I-cache (0) and a D-cache (1); ext request one cycle after sampling.
// Requesters stall by holding strobes until their ack; a stuck memory is aborted after TIMEOUT cycles with err.
module mem_arbiter
    import mem_pkg::*;
#(
    parameter int WORD_SIZE  = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int TIMEOUT    = DEF_TIMEOUT
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  req0_re,
    input  logic                  req0_wr,
    input  logic [ADDR_WIDTH-1:0] req0_addr,
    input  logic [WORD_SIZE-1:0]  req0_data_in,
    output logic [WORD_SIZE-1:0]  req0_data_out,
    output logic                  req0_ack,

    input  logic                  req1_re,
    input  logic                  req1_wr,
    input  logic [ADDR_WIDTH-1:0] req1_addr,
    input  logic [WORD_SIZE-1:0]  req1_data_in,
    output logic [WORD_SIZE-1:0]  req1_data_out,
    output logic                  req1_ack,

    output logic [ADDR_WIDTH-1:0] ext_addr,
    output logic [WORD_SIZE-1:0]  ext_data_out,
    output logic                  ext_re,
    output logic                  ext_wr,
    input  logic [WORD_SIZE-1:0]  ext_data_in,
    input  logic                  ext_ack,

    output logic                  err
);

    localparam logic [CNT_W-1:0] TO_CNT = CNT_W'(TIMEOUT);

    state_t                r_state;
    state_t                w_next;
    logic                  r_grant;
    logic                  r_last_grant;
    logic                  r_wr;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [WORD_SIZE-1:0]  r_data;
    logic [CNT_W-1:0]      r_cnt;

    logic [1:0]            w_req;
    logic                  w_win;
    logic                  w_busy;
    logic                  w_done;
    logic                  w_abort;
    logic                  w_fin;
    logic [WORD_SIZE-1:0]  w_rdata;

    assign w_req = {req1_re | req1_wr, req0_re | req0_wr};

    rr_arb2 u_rr_arb2 (
        .req        (w_req),
        .last_grant (r_last_grant),
        .grant      (w_win)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // A memory ack in the same cycle the counter hits TIMEOUT completes normally.
    always_comb begin
        w_next  = r_state;
        w_done  = 1'b0;
        w_abort = 1'b0;
        case (r_state)
            IDLE: begin
                if (|w_req) begin
                    w_next = BUSY;
                end
            end
            BUSY: begin
                if (ext_ack) begin
                    w_done = 1'b1;
                    w_next = IDLE;
                end else if (r_cnt == TO_CNT) begin
                    w_abort = 1'b1;
                    w_next  = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_grant      <= 1'b0;
            r_last_grant <= 1'b1;
            r_wr         <= 1'b0;
            r_addr       <= '0;
            r_data       <= '0;
            r_cnt        <= '0;
        end else if (r_state == IDLE && |w_req) begin
            r_grant      <= w_win;
            r_last_grant <= w_win;
            r_wr         <= w_win ? req1_wr      : req0_wr;
            r_addr       <= w_win ? req1_addr    : req0_addr;
            r_data       <= w_win ? req1_data_in : req0_data_in;
            r_cnt        <= '0;
        end else if (r_state == BUSY) begin
            r_cnt        <= r_cnt + 1'b1;
        end
    end

    assign w_busy       = (r_state == BUSY);
    assign ext_re       = w_busy & ~r_wr;
    assign ext_wr       = w_busy &  r_wr;
    assign ext_addr     = r_addr;
    assign ext_data_out = r_data;

    // Read data is masked outside BUSY and on abort so a stale bus value never reaches a cache.
    assign w_fin         = w_done | w_abort;
    assign w_rdata       = (w_busy && !w_abort) ? ext_data_in : '0;
    assign req0_ack      = w_fin & ~r_grant;
    assign req1_ack      = w_fin &  r_grant;
    assign req0_data_out = r_grant ? '0 : w_rdata;
    assign req1_data_out = r_grant ? w_rdata : '0;
    assign err           = w_abort;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: stimulus queues expected acks, a negedge monitor scores them.
module tb_mem_arbiter;

    localparam int W  = 32;
    localparam int A  = 32;
    localparam int TO = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         req0_re = 1'b0, req0_wr = 1'b0;
    logic [A-1:0] req0_addr = '0;
    logic [W-1:0] req0_data_in = '0;
    logic [W-1:0] req0_data_out;
    logic         req0_ack;
    logic         req1_re = 1'b0, req1_wr = 1'b0;
    logic [A-1:0] req1_addr = '0;
    logic [W-1:0] req1_data_in = '0;
    logic [W-1:0] req1_data_out;
    logic         req1_ack;
    logic [A-1:0] ext_addr;
    logic [W-1:0] ext_data_out;
    logic         ext_re, ext_wr;
    logic [W-1:0] ext_data_in = '0;
    logic         ext_ack = 1'b0;
    logic         err;

    mem_arbiter #(.WORD_SIZE(W), .ADDR_WIDTH(A), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .req0_re(req0_re), .req0_wr(req0_wr), .req0_addr(req0_addr),
        .req0_data_in(req0_data_in), .req0_data_out(req0_data_out), .req0_ack(req0_ack),
        .req1_re(req1_re), .req1_wr(req1_wr), .req1_addr(req1_addr),
        .req1_data_in(req1_data_in), .req1_data_out(req1_data_out), .req1_ack(req1_ack),
        .ext_addr(ext_addr), .ext_data_out(ext_data_out), .ext_re(ext_re), .ext_wr(ext_wr),
        .ext_data_in(ext_data_in), .ext_ack(ext_ack), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          who;
        logic [31:0] dat;
        bit          er;
        int          cyc;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] mem [logic [31:0]];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          mem_lat = 1;
    bit          mem_dead = 1'b0;
    bit          spurious = 1'b0;
    bit          hold = 1'b0;
    int          wait_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    task automatic push(input bit who, input logic [31:0] dat, input bit er, input int c);
        exp_t e;
        e.who = who; e.dat = dat; e.er = er; e.cyc = c;
        exp_q.push_back(e);
    endtask

    task automatic drain(input int max_cyc);
        int n = 0;
        while (exp_q.size() != 0 && n < max_cyc) begin
            @(negedge clk);
            #2;
            n++;
        end
        chk("drain_outstanding", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    // Memory model: answers after mem_lat BUSY cycles, never when mem_dead.
    always @(posedge clk) begin
        #2;
        if (ext_re || ext_wr) begin
            if (!mem_dead && wait_cnt == mem_lat) begin
                ext_ack = 1'b1;
                if (ext_wr) begin
                    mem[ext_addr] = ext_data_out;
                    ext_data_in   = '0;
                end else begin
                    ext_data_in = mem.exists(ext_addr) ? mem[ext_addr] : '0;
                end
            end else begin
                ext_ack     = 1'b0;
                ext_data_in = 32'hA5A5_5A5A;
            end
            wait_cnt++;
        end else begin
            ext_ack     = spurious;
            ext_data_in = spurious ? 32'h0BAD_F00D : '0;
            wait_cnt    = 0;
        end
    end

    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst && (req0_ack || req1_ack || err)) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_ack: got ack0=%b ack1=%b err=%b want none", req0_ack, req1_ack, err);
            end else begin
                e = exp_q.pop_front();
                chk("ack_sel", 32'({req1_ack, req0_ack}), e.who ? 32'd2 : 32'd1);
                chk("ack_data", e.who ? req1_data_out : req0_data_out, e.dat);
                chk("ack_other_data", e.who ? req0_data_out : req1_data_out, 32'd0);
                chk("ack_err", 32'(err), 32'(e.er));
                if (e.cyc >= 0) chk("ack_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    always @(negedge clk) begin : dropper
        if (!hold) begin
            if (req0_ack) begin #1; req0_re = 1'b0; req0_wr = 1'b0; end
            if (req1_ack) begin #1; req1_re = 1'b0; req1_wr = 1'b0; end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no end of test, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int acks;
        mem[32'h10]  = 32'h1111_0000;
        mem[32'h40]  = 32'hDEAD_BEEF;
        mem[32'h100] = 32'hA0A0_A0A0;
        mem[32'h104] = 32'hB1B1_B1B1;

        // Reset with junk on the memory bus: every output must stay 0.
        spurious = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_ctrl", 32'({ext_re, ext_wr, req0_ack, req1_ack, err}), 32'd0);
        chk("rst_ext_addr", ext_addr, 32'd0);
        chk("rst_ext_wdata", ext_data_out, 32'd0);
        chk("rst_rdata0", req0_data_out, 32'd0);
        chk("rst_rdata1", req1_data_out, 32'd0);
        spurious = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // Collision straight after reset: req0 wins the first tie.
        @(negedge clk); #1;
        mem_lat = 1;
        n = cyc;
        req0_re = 1'b1; req0_addr = 32'h10;
        req1_wr = 1'b1; req1_addr = 32'hF0; req1_data_in = 32'hFFFF_FFFF;
        push(1'b0, 32'h1111_0000, 1'b0, n + 2);
        push(1'b1, 32'h0, 1'b0, n + 5);
        drain(40);

        @(negedge clk); #1;
        n = cyc;
        req1_re = 1'b1; req1_addr = 32'hF0;
        push(1'b1, 32'hFFFF_FFFF, 1'b0, n + 2);
        drain(40);

        // Single read: ext_re appears one cycle after sampling.
        @(negedge clk); #1;
        n = cyc;
        req0_re = 1'b1; req0_addr = 32'h40;
        chk("rd_ext_re_before", 32'(ext_re), 32'd0);
        push(1'b0, 32'hDEAD_BEEF, 1'b0, n + 2);
        @(negedge clk);
        chk("rd_ext_re_next", 32'(ext_re), 32'd1);
        chk("rd_ext_addr", ext_addr, 32'h40);
        drain(40);

        // re and wr together behave as a write.
        @(negedge clk); #1;
        n = cyc;
        req0_re = 1'b1; req0_wr = 1'b1; req0_addr = 32'h80; req0_data_in = 32'h1234_5678;
        push(1'b0, 32'h0, 1'b0, n + 2);
        @(negedge clk);
        chk("rw_ext_op", 32'({ext_re, ext_wr}), 32'd1);
        chk("rw_ext_wdata", ext_data_out, 32'h1234_5678);
        drain(40);

        @(negedge clk); #1;
        n = cyc;
        req0_re = 1'b1; req0_addr = 32'h80;
        push(1'b0, 32'h1234_5678, 1'b0, n + 2);
        drain(40);

        // Memory ack while IDLE is ignored.
        @(negedge clk);
        spurious = 1'b1;
        repeat (4) @(negedge clk);
        chk("idle_ack_ignored", 32'({ext_re, ext_wr, req0_ack, req1_ack, err}), 32'd0);
        spurious = 1'b0;
        repeat (2) @(negedge clk);

        // Timeout: abort in the cycle the counter reaches 8.
        mem_dead = 1'b1;
        @(negedge clk); #1;
        n = cyc;
        req1_re = 1'b1; req1_addr = 32'h200;
        push(1'b1, 32'h0, 1'b1, n + 9);
        drain(40);
        @(negedge clk);
        chk("to_then_idle", 32'({ext_re, ext_wr}), 32'd0);
        mem_dead = 1'b0;

        // Ack in the timeout cycle wins; one cycle earlier is an ordinary ack.
        @(negedge clk); #1;
        mem_lat = 8;
        n = cyc;
        req0_re = 1'b1; req0_addr = 32'h40;
        push(1'b0, 32'hDEAD_BEEF, 1'b0, n + 9);
        drain(40);

        @(negedge clk); #1;
        mem_lat = 7;
        n = cyc;
        req1_re = 1'b1; req1_addr = 32'h10;
        push(1'b1, 32'h1111_0000, 1'b0, n + 8);
        drain(40);

        // Fairness from a fresh reset with both requests held.
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk); #1;
        hold = 1'b1;
        mem_lat = 0;
        req0_re = 1'b1; req0_addr = 32'h100;
        req1_re = 1'b1; req1_addr = 32'h104;
        for (int i = 0; i < 6; i++) push(i[0], i[0] ? 32'hB1B1_B1B1 : 32'hA0A0_A0A0, 1'b0, -1);
        acks = 0;
        n = 0;
        while (acks < 6 && n < 200) begin
            @(negedge clk);
            n++;
            if (req0_ack || req1_ack) acks++;
        end
        #1;
        req0_re = 1'b0; req1_re = 1'b0;
        hold = 1'b0;
        chk("fair_ack_count", 32'(acks), 32'd6);
        drain(20);
        repeat (4) @(negedge clk);

        // Reset mid-write: outputs drop at once, nothing completes afterwards.
        mem_dead = 1'b1;
        @(negedge clk); #1;
        req1_wr = 1'b1; req1_addr = 32'h300; req1_data_in = 32'h5555_AAAA;
        repeat (3) @(negedge clk);
        chk("rb_busy_write", 32'(ext_wr), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("rb_ctrl", 32'({ext_re, ext_wr, req0_ack, req1_ack, err}), 32'd0);
        chk("rb_ext_addr", ext_addr, 32'd0);
        chk("rb_ext_wdata", ext_data_out, 32'd0);
        chk("rb_rdata", req0_data_out | req1_data_out, 32'd0);
        req1_wr = 1'b0;
        @(negedge clk);
        mem_dead = 1'b0;
        rst = 1'b1;
        repeat (12) @(negedge clk);
        chk("rb_quiet", 32'({ext_re, ext_wr}), 32'd0);
        chk("rb_no_write", 32'(mem.exists(32'h300)), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The module SHALL have parameter WORD_SIZE, default 32, the data width in bits.
REQ-002 The module SHALL have parameter ADDR_WIDTH, default 32, the byte-address width.
REQ-003 The module SHALL have parameter TIMEOUT, default 255, the maximum number of BUSY cycles before abort.
REQ-004 The module SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-005 The module SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-006 The module SHALL have ports req0_re and req0_wr, inputs, 1 bit each: requester 0 (instruction cache) read and write strobes.
REQ-007 The module SHALL have ports req0_addr (ADDR_WIDTH) and req0_data_in (WORD_SIZE), inputs: requester 0 address and write data.
REQ-008 The module SHALL have ports req0_data_out (WORD_SIZE) and req0_ack (1 bit), outputs: requester 0 read data and completion pulse.
REQ-009 The module SHALL have ports req1_re, req1_wr, req1_addr, req1_data_in, req1_data_out and req1_ack, identical to REQ-006 to REQ-008 but for requester 1 (data cache).
REQ-010 The module SHALL have ports ext_addr (ADDR_WIDTH), ext_data_out (WORD_SIZE), ext_re (1 bit) and ext_wr (1 bit), outputs: the shared memory request.
REQ-011 The module SHALL have ports ext_data_in (WORD_SIZE) and ext_ack (1 bit), inputs: memory read data and ready.
REQ-012 The module SHALL have port err, output, 1 bit: one-cycle pulse on timeout abort.

Function
REQ-013 A requester SHALL hold re or wr, addr and data stable from assertion until its ack cycle.
REQ-014 The FSM SHALL have exactly two states: IDLE and BUSY.
REQ-015 In IDLE with no request pending, the FSM SHALL remain in IDLE and drive ext_re=ext_wr=0.
REQ-016 In IDLE with at least one request pending, the arbiter SHALL, at the clock edge, latch the winner's addr, data and op into registers, set grant, and enter BUSY.
REQ-017 ext_* SHALL be driven from those latch registers, so the memory request appears one cycle after the request is sampled.
REQ-018 If only one requester is pending, it SHALL win.
REQ-019 If both requesters are pending, the one not granted last SHALL win (round-robin); after reset last_grant = 1, so requester 0 wins the first tie.
REQ-020 If a requester asserts re and wr together, the request SHALL be treated as a write.
REQ-021 In BUSY, ext_re or ext_wr SHALL stay asserted, per the latched op, until ext_ack or timeout.
REQ-022 When ext_ack=1 in BUSY, the granted reqN_ack SHALL be 1 combinationally in that same cycle.
REQ-023 reqN_data_out SHALL equal ext_data_in for the granted requester and zero for the other.
REQ-024 When ext_ack=1 in BUSY, the FSM SHALL return to IDLE at the next edge, with ext_re/ext_wr=0 in that IDLE cycle.
REQ-025 A request still asserted in the IDLE cycle that follows an ack SHALL be treated as a new request.
REQ-026 An 8-bit cycle counter SHALL clear on entry to BUSY and increment each BUSY cycle.
REQ-027 If the counter reaches TIMEOUT without ext_ack, the block SHALL pulse err for one cycle, pulse the granted ack with data_out=0, and return to IDLE.
REQ-028 If ext_ack arrives in the same cycle the counter reaches TIMEOUT, the ack SHALL win and err SHALL stay 0.
REQ-029 ext_ack received while in IDLE SHALL be ignored.
REQ-030 reqN_ack and err SHALL never be asserted for more than one consecutive cycle per transaction.

Reset
REQ-031 With rst=0, asynchronously, the block SHALL set state=IDLE, grant=0, last_grant=1, counter=0, and all latch registers to 0.
REQ-032 Under the same condition, the block SHALL drive all outputs to 0.
REQ-033 When reset is asserted mid-transaction, the block SHALL abandon the transaction silently, with no ack and no err.

Structure
REQ-034 The state encoding (IDLE=0, BUSY=1) and the default TIMEOUT constant SHALL reside in shared package mem_pkg.
REQ-035 The round-robin grant logic SHALL be a sub-module rr_arb2, with inputs req[1:0] and last_grant and output grant; all else SHALL be flat.

Verification
REQ-036 Single read: req0 reads 0x40 with the memory model holding 0xDEADBEEF there -> ext_re=1 one cycle later, req0_ack pulses, and req0_data_out=0xDEADBEEF.
REQ-037 Collision: req0 reads 0x10 and req1 writes 0xFFFFFFFF to 0xF0 in the same cycle after reset -> req0 is served first, then req1, with exactly one ack each.
REQ-038 Fairness: both requesters hold requests continuously for 6 transactions -> grants alternate 0,1,0,1,0,1.
REQ-039 Timeout: the memory model never asserts ready, with TIMEOUT=8 -> err and req1_ack pulse exactly 8 BUSY cycles after grant, then the FSM is IDLE.
REQ-040 Reset mid-BUSY: rst is pulled low during a req1 write -> all outputs are 0 immediately, and no ack follows after reset releases.
REQ-041 Boundary: ext_ack arrives in the TIMEOUT cycle -> ack=1 and err=0.
